// File: rtl/cfg_burst_ctrl.sv
// Node configuration controller: queues config flits and runs WRITE fill bursts
// and READ bursts against the node configurator, replying to a per-command XY.
module cfg_burst_ctrl #(
  parameter int FW     = 59,
  parameter int FTW    = 3,
  parameter int ATW    = 3,
  parameter int CDW    = 21,
  parameter int CAW    = 15,
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int DEPTH  = 4,
  parameter int BLW    = 4,
  parameter int RD_LAT = 1,
  parameter int R_FLG  = 36
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spk_in_config_we,
  input  logic [FW-1:0]  spk_in_config_wdata,
  output logic           config_spk_in_credit,
  input  logic           axon_busy,
  input  logic           work_config_busy,
  output logic           config_spk_out_we,
  output logic [FW-1:0]  config_spk_out_wdata,
  input  logic           spk_out_config_full,
  output logic           config_we,
  output logic [CAW-1:0] config_waddr,
  output logic [CDW-1:0] config_wdata,
  output logic           config_re,
  output logic [CAW-1:0] config_raddr,
  input  logic [CDW-1:0] config_rdata,
  output logic           cmd_err,
  output logic           ctrl_idle,
  output logic [2:0]     dbg_state
);

  localparam int LAW = CAW - ATW;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [FTW-1:0] T_WRITE   = FTW'(3'b110);
  localparam logic [FTW-1:0] T_READ    = FTW'(3'b111);
  localparam logic [ATW-1:0] CLS_WGT   = ATW'(3'b001);
  localparam logic [ATW-1:0] CLS_DST   = ATW'(3'b010);
  localparam logic [ATW-1:0] CLS_VMM   = ATW'(3'b100);
  localparam logic [ATW-1:0] CLS_VMB   = ATW'(3'b110);
  localparam logic [PW:0]    FULL_CNT  = (PW+1)'(DEPTH);
  localparam logic [PW:0]    ONE_CNT   = (PW+1)'(1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_RUN   = 3'd1,
    S_R_ISSUE = 3'd2,
    S_R_WAIT  = 3'd3,
    S_R_SEND  = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Flit intake is valid-only: a flit is taken whenever spk_in_config_we is high
  // and a slot exists (or the head is popped in the same cycle); each pop returns
  // one credit pulse so the sender can track free slots.
  logic [FW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count_q, count_d;
  logic          fifo_empty, fifo_full, push, pop, overflow;
  logic [FW-1:0] head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign push       = spk_in_config_we && (!fifo_full || pop);
  assign overflow   = spk_in_config_we && fifo_full && !pop;
  assign head       = mem[rd_ptr];

  logic [FTW-1:0]   head_type;
  logic [XW+YW-1:0] head_xy;
  logic [BLW-1:0]   head_len;
  logic [CAW-1:0]   head_addr;
  logic [CDW-1:0]   head_data;
  logic             unused_head_bits;

  assign head_type        = head[FW-1 -: FTW];
  assign head_xy          = head[R_FLG+BLW +: XW+YW];
  assign head_len         = head[R_FLG +: BLW];
  assign head_addr        = head[CDW +: CAW];
  assign head_data        = head[CDW-1:0];
  assign unused_head_bits = ^head[FW-FTW-1 : R_FLG+BLW+XW+YW];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + ONE_CNT;
    else if (!push && pop) count_d = count_q - ONE_CNT;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= spk_in_config_wdata;
  end

  // Burst context of the command in flight
  logic [CAW-1:0]   addr_q, addr_inc;
  logic [BLW-1:0]   cnt_q;
  logic [CDW-1:0]   data_q, rdata_q;
  logic [XW+YW-1:0] xy_q;
  logic [WCW-1:0]   wait_q;
  logic [CAW-1:0]   waddr_q, raddr_q;
  logic [CDW-1:0]   wdata_q;
  logic [FW-1:0]    out_q, reply;
  logic             cmd_err_q, ctrl_idle_q;
  logic             cls_busy, bad_type, capture, send;

  // Only the in-class offset advances; the class field never changes mid-burst.
  assign addr_inc = {addr_q[CAW-1 -: ATW], addr_q[LAW-1:0] + LAW'(1)};

  always_comb begin
    cls_busy = 1'b0;
    case (addr_q[CAW-1 -: ATW])
      CLS_WGT, CLS_VMB: cls_busy = axon_busy;
      CLS_DST, CLS_VMM: cls_busy = work_config_busy;
      default:          cls_busy = 1'b0;
    endcase
  end

  always_comb begin
    reply                       = '0;
    reply[FW-1 -: FTW]          = T_READ;
    reply[R_FLG+BLW +: XW+YW]   = xy_q;
    reply[CDW +: CAW]           = addr_q;
    reply[CDW-1:0]              = rdata_q;
  end

  always_comb begin
    state_d   = state_q;
    config_we = 1'b0;
    config_re = 1'b0;
    capture   = 1'b0;
    send      = 1'b0;
    bad_type  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          case (head_type)
            T_WRITE: state_d  = S_W_RUN;
            T_READ:  state_d  = S_R_ISSUE;
            default: bad_type = 1'b1;
          endcase
        end
      end
      S_W_RUN: begin
        if (!cls_busy) begin
          config_we = 1'b1;
          if (cnt_q == '0) state_d = S_IDLE;
        end
      end
      S_R_ISSUE: begin
        if (!cls_busy) begin
          config_re = 1'b1;
          state_d   = S_R_WAIT;
        end
      end
      S_R_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          capture = 1'b1;
          state_d = S_R_SEND;
        end
      end
      S_R_SEND: begin
        if (!spk_out_config_full && !work_config_busy) begin
          send    = 1'b1;
          state_d = (cnt_q == '0) ? S_IDLE : S_R_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      xy_q        <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      out_q       <= '0;
      cmd_err_q   <= 1'b0;
      ctrl_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cmd_err_q   <= cmd_err_q | overflow | bad_type;
      ctrl_idle_q <= (count_d == '0) && (state_d == S_IDLE);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr_q <= head_addr;
        cnt_q  <= head_len;
        data_q <= head_data;
        xy_q   <= head_xy;
      end
      if (config_we) begin
        waddr_q <= addr_q;
        wdata_q <= data_q;
        addr_q  <= addr_inc;
        if (cnt_q != '0) cnt_q <= cnt_q - BLW'(1);
      end
      if (config_re) begin
        raddr_q <= addr_q;
        wait_q  <= '0;
      end
      if (state_q == S_R_WAIT) wait_q <= wait_q + WCW'(1);
      if (capture) rdata_q <= config_rdata;
      if (send) begin
        out_q <= reply;
        if (cnt_q != '0) begin
          addr_q <= addr_inc;
          cnt_q  <= cnt_q - BLW'(1);
        end
      end
    end
  end

  // Write/read/reply buses show live values on their strobe and hold otherwise.
  assign config_waddr         = config_we ? addr_q : waddr_q;
  assign config_wdata         = config_we ? data_q : wdata_q;
  assign config_raddr         = config_re ? addr_q : raddr_q;
  assign config_spk_out_we    = send;
  assign config_spk_out_wdata = send ? reply : out_q;
  assign config_spk_in_credit = pop;
  assign cmd_err              = cmd_err_q;
  assign ctrl_idle            = ctrl_idle_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_cfg_burst_ctrl.sv
// Bench for cfg_burst_ctrl: directed and random command bursts checked against
// a burst-level reference model and a configurator memory model.
module tb_cfg_burst_ctrl;
  localparam int FW = 59, FTW = 3, ATW = 3, CDW = 21, CAW = 15, XW = 4, YW = 4;
  localparam int DEPTH = 4, BLW = 4, RD_LAT = 2, R_FLG = 36;
  localparam int EW = CAW + CDW;
  localparam logic [2:0] T_W = 3'b110, T_R = 3'b111;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           spk_in_config_we = 1'b0;
  logic [FW-1:0]  spk_in_config_wdata = '0;
  logic           config_spk_in_credit;
  logic           axon_busy = 1'b0, work_config_busy = 1'b0, spk_out_config_full = 1'b0;
  logic           config_spk_out_we;
  logic [FW-1:0]  config_spk_out_wdata;
  logic           config_we, config_re;
  logic [CAW-1:0] config_waddr, config_raddr;
  logic [CDW-1:0] config_wdata;
  logic [CDW-1:0] config_rdata = '0;
  logic           cmd_err, ctrl_idle;
  logic [2:0]     dbg_state;

  cfg_burst_ctrl #(.FW(FW), .FTW(FTW), .ATW(ATW), .CDW(CDW), .CAW(CAW), .XW(XW), .YW(YW),
                   .DEPTH(DEPTH), .BLW(BLW), .RD_LAT(RD_LAT), .R_FLG(R_FLG)) dut (
    .clk(clk), .rst_n(rst_n),
    .spk_in_config_we(spk_in_config_we), .spk_in_config_wdata(spk_in_config_wdata),
    .config_spk_in_credit(config_spk_in_credit),
    .axon_busy(axon_busy), .work_config_busy(work_config_busy),
    .config_spk_out_we(config_spk_out_we), .config_spk_out_wdata(config_spk_out_wdata),
    .spk_out_config_full(spk_out_config_full),
    .config_we(config_we), .config_waddr(config_waddr), .config_wdata(config_wdata),
    .config_re(config_re), .config_raddr(config_raddr), .config_rdata(config_rdata),
    .cmd_err(cmd_err), .ctrl_idle(ctrl_idle), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0, failures = 0;
  logic [EW-1:0] exp_w[$], obs_w[$];
  logic [FW-1:0] exp_r[$], obs_r[$];
  int w_cyc[$], re_cyc[$], r_cyc[$], credit_cyc[$];
  int exp_credit = 0, obs_credit = 0;
  logic [CDW-1:0] dev_mem   [0:(1<<CAW)-1];
  logic [CDW-1:0] model_mem [0:(1<<CAW)-1];
  logic           hv [0:RD_LAT];
  logic [CAW-1:0] ha [0:RD_LAT];

  // Monitor and configurator model, sampled mid-cycle after inputs settle
  always @(negedge clk) begin
    #2;
    if (config_we) begin
      obs_w.push_back({config_waddr, config_wdata});
      w_cyc.push_back(cyc);
      dev_mem[config_waddr] = config_wdata;
    end
    if (config_re) re_cyc.push_back(cyc);
    if (config_spk_out_we) begin
      obs_r.push_back(config_spk_out_wdata);
      r_cyc.push_back(cyc);
    end
    if (config_spk_in_credit) begin
      obs_credit++;
      credit_cyc.push_back(cyc);
    end
    for (int i = RD_LAT; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = config_re;
    ha[0] = config_raddr;
    config_rdata = (hv[RD_LAT] === 1'b1) ? dev_mem[ha[RD_LAT]] : CDW'($urandom);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expands one command into the writes/replies it must cause.
  task automatic model_cmd(input logic [2:0] ty, input logic [7:0] xy, input int len,
                           input logic [CAW-1:0] addr, input logic [CDW-1:0] data);
    int cls, low, a;
    cls = int'(addr) / 4096;
    low = int'(addr) % 4096;
    exp_credit++;
    for (int i = 0; i < len; i++) begin
      a = cls * 4096 + (low + i) % 4096;
      if (ty == T_W) begin
        model_mem[a] = data;
        exp_w.push_back({CAW'(a), data});
      end else if (ty == T_R) begin
        exp_r.push_back({3'b111, 8'h00, xy, 4'h0, CAW'(a), model_mem[a]});
      end
    end
  endtask

  task automatic send(input logic [2:0] ty, input logic [7:0] xy, input int len,
                      input logic [CAW-1:0] addr, input logic [CDW-1:0] data, input bit modeled);
    logic [FW-1:0] f;
    if (modeled) model_cmd(ty, xy, len, addr, data);
    f = '0;
    f[58:56] = ty;
    f[55:48] = 8'($urandom);
    f[47:40] = xy;
    f[39:36] = 4'(len - 1);
    f[35:21] = addr;
    f[20:0]  = data;
    spk_in_config_we    = 1'b1;
    spk_in_config_wdata = f;
    tick();
    spk_in_config_we    = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget, input bit rnd);
    int n = 0;
    do begin
      if (rnd) begin
        axon_busy           = ($urandom_range(0, 3) == 0);
        work_config_busy    = ($urandom_range(0, 3) == 0);
        spk_out_config_full = ($urandom_range(0, 3) == 0);
      end
      tick();
      n++;
    end while (ctrl_idle !== 1'b1 && n < budget);
    axon_busy = 1'b0;
    work_config_busy = 1'b0;
    spk_out_config_full = 1'b0;
    check($sformatf("%s_idle", tag), ctrl_idle, 1'b1);
  endtask

  task automatic clear_sb();
    exp_w.delete(); obs_w.delete(); exp_r.delete(); obs_r.delete();
    w_cyc.delete(); re_cyc.delete(); r_cyc.delete(); credit_cyc.delete();
    exp_credit = 0;
    obs_credit = 0;
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s_wcount", tag), obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < obs_w.size(); i++)
      check($sformatf("%s_w%0d", tag, i), obs_w[i], exp_w[i]);
    check($sformatf("%s_rcount", tag), obs_r.size(), exp_r.size());
    for (int i = 0; i < exp_r.size() && i < obs_r.size(); i++)
      check($sformatf("%s_r%0d", tag, i), obs_r[i], exp_r[i]);
    check($sformatf("%s_credit", tag), obs_credit, exp_credit);
    clear_sb();
  endtask

  task automatic check_reset_outputs(input string tag);
    check($sformatf("%s_we", tag), config_we, 1'b0);
    check($sformatf("%s_re", tag), config_re, 1'b0);
    check($sformatf("%s_waddr", tag), config_waddr, '0);
    check($sformatf("%s_wdata", tag), config_wdata, '0);
    check($sformatf("%s_raddr", tag), config_raddr, '0);
    check($sformatf("%s_out_we", tag), config_spk_out_we, 1'b0);
    check($sformatf("%s_out_wdata", tag), config_spk_out_wdata, '0);
    check($sformatf("%s_credit", tag), config_spk_in_credit, 1'b0);
    check($sformatf("%s_cmd_err", tag), cmd_err, 1'b0);
    check($sformatf("%s_ctrl_idle", tag), ctrl_idle, 1'b0);
    check($sformatf("%s_state", tag), dbg_state, 3'd0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int rel, n;
    logic [CDW-1:0] v;
    for (int i = 0; i < (1 << CAW); i++) begin
      v = CDW'($urandom);
      dev_mem[i]   = v;
      model_mem[i] = v;
    end
    for (int i = 0; i <= RD_LAT; i++) begin
      hv[i] = 1'b0;
      ha[i] = '0;
    end
    tick();
    tick();
    #1;
    check_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_reset_idle", ctrl_idle, 1'b1);
    clear_sb();

    // Single-word write, first beat one cycle after the pop
    send(T_W, 8'h00, 1, 15'h0005, 21'h1ABCD, 1'b1);
    wait_idle("t1", 200, 1'b0);
    check("t1_credits", credit_cyc.size(), 1);
    if (w_cyc.size() > 0 && credit_cyc.size() > 0)
      check("t1_latency", w_cyc[0] - credit_cyc[0], 1);
    compare_all("t1");

    // WGT_MEM burst held by axon_busy, then back-to-back beats
    axon_busy = 1'b1;
    send(T_W, 8'h00, 4, 15'h1000, CDW'($urandom), 1'b1);
    tick();
    tick();
    tick();
    axon_busy = 1'b0;
    rel = cyc;
    wait_idle("t2", 200, 1'b0);
    if (w_cyc.size() == 4) begin
      check("t2_first_beat", w_cyc[0], rel);
      check("t2_back_to_back", w_cyc[3] - w_cyc[0], 3);
    end
    compare_all("t2");

    // Three-word read burst with per-word timing
    send(T_R, 8'h34, 3, 15'h2010, '0, 1'b1);
    wait_idle("t3", 300, 1'b0);
    for (int i = 0; i < 3 && i < re_cyc.size() && i < r_cyc.size(); i++)
      check($sformatf("t3_re_to_reply%0d", i), r_cyc[i] - re_cyc[i], RD_LAT + 1);
    for (int i = 0; i < 2 && i + 1 < re_cyc.size(); i++)
      check($sformatf("t3_word_period%0d", i), re_cyc[i+1] - re_cyc[i], RD_LAT + 2);
    compare_all("t3");

    // In-class address wrap for a write and a read
    send(T_W, 8'h00, 2, 15'h0FFF, CDW'($urandom), 1'b1);
    wait_idle("t4w", 200, 1'b0);
    compare_all("t4w");
    send(T_R, 8'hC5, 2, 15'h0FFF, '0, 1'b1);
    wait_idle("t4r", 200, 1'b0);
    compare_all("t4r");

    // Random command batches under random stalls
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        send(($urandom_range(0, 1) == 1) ? T_R : T_W, 8'($urandom), $urandom_range(1, 8),
             CAW'($urandom), CDW'($urandom), 1'b1);
      wait_idle($sformatf("rnd%0d", b), 4000, 1'b1);
      compare_all($sformatf("rnd%0d", b));
    end

    // Overflow while a READ reply is blocked at the head
    spk_out_config_full = 1'b1;
    send(T_R, 8'h5A, 1, 15'h0123, '0, 1'b1);
    for (int i = 0; i < RD_LAT + 4; i++) tick();
    for (int k = 0; k < DEPTH; k++)
      send(T_W, 8'h00, 1, CAW'(16'h0200 + k), CDW'($urandom), 1'b1);
    check("t5_no_err_at_full", cmd_err, 1'b0);
    send(T_W, 8'h00, 1, 15'h0300, CDW'($urandom), 1'b0);
    check("t5_overflow_err", cmd_err, 1'b1);
    spk_out_config_full = 1'b0;
    wait_idle("t5", 400, 1'b0);
    compare_all("t5");
    check("t5_err_sticky", cmd_err, 1'b1);

    // Unknown flit type
    do_reset();
    check("t5b_err_cleared", cmd_err, 1'b0);
    clear_sb();
    send(3'b011, 8'h00, 1, 15'h0040, CDW'($urandom), 1'b1);
    wait_idle("t5b", 100, 1'b0);
    check("t5b_type_err", cmd_err, 1'b1);
    compare_all("t5b");

    // Reset during the wait phase of a four-word read
    do_reset();
    clear_sb();
    send(T_R, 8'h11, 4, 15'h3000, '0, 1'b1);
    n = 0;
    while (config_re !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("t6_re_seen", config_re, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("t6_we", config_we, 1'b0);
    check("t6_re", config_re, 1'b0);
    check("t6_out_we", config_spk_out_we, 1'b0);
    check("t6_out_wdata", config_spk_out_wdata, '0);
    check("t6_credit", config_spk_in_credit, 1'b0);
    check("t6_ctrl_idle_in_reset", ctrl_idle, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_ctrl_idle", ctrl_idle, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    check("t6_no_reply", obs_r.size(), 0);
    check("t6_one_credit", obs_credit, 1);
    check("t6_cmd_err", cmd_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
